// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// types_pkg: shared types and default parameters for board_io_sampler.
// Rev 1.0
// ============================================================================
package types_pkg;

   typedef logic [15:0] word_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } snap_state_t;

   localparam int DEF_NUM_BTNS    = 5;
   localparam int DEF_SW_BITS     = 16;
   localparam int DEF_LED_BITS    = 16;
   localparam int DEF_TICK_DIV    = 1000;
   localparam int DEF_DEB_SAMPLES = 4;

endpackage
`default_nettype wire

// File: rtl/board_io_sampler_if.sv
`default_nettype none
// ============================================================================
// board_io_sampler_if: snapshot valid/ready handshake (SNAP_TIME with SNAP_TIMESTAMP_EN).
// Rev 1.0
// ============================================================================
interface board_io_sampler_if
   import types_pkg::*;
#(
   parameter int SW_BITS  = DEF_SW_BITS,
   parameter int LED_BITS = DEF_LED_BITS
);
   logic                SNAP_VALID;
   logic                SNAP_READY;
   logic [SW_BITS-1:0]  SNAP_SW;
   logic [LED_BITS-1:0] SNAP_LED;
`ifdef SNAP_TIMESTAMP_EN
   logic [31:0]         SNAP_TIME;

   modport master (output SNAP_VALID, SNAP_SW, SNAP_LED, SNAP_TIME, input SNAP_READY);
   modport slave  (input SNAP_VALID, SNAP_SW, SNAP_LED, SNAP_TIME, output SNAP_READY);
`else
   modport master (output SNAP_VALID, SNAP_SW, SNAP_LED, input SNAP_READY);
   modport slave  (input SNAP_VALID, SNAP_SW, SNAP_LED, output SNAP_READY);
`endif
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce: tick-sampled debouncer with one-cycle rising-edge press pulse.
// Rev 1.0
// ============================================================================
module btn_debounce
   import types_pkg::*;
#(
   parameter int DEB_SAMPLES = DEF_DEB_SAMPLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic sample,
   output logic level,
   output logic press
);
   // Only DEB_SAMPLES-1 past samples are stored; the current one completes the window.
   logic [DEB_SAMPLES-2:0] hist;
   logic [DEB_SAMPLES-1:0] window;
   logic                   level_d;

   assign window = {hist, sample};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist    <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_d <= level;
         press   <= level & ~level_d;
         if (tick) begin
            hist <= window[DEB_SAMPLES-2:0];
            if (&window)
               level <= 1'b1;
            else if (~|window)
               level <= 1'b0;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/board_io_sampler.sv
`default_nettype none
// ============================================================================
// board_io_sampler: synchronise/sample board switches and buttons, snapshot handshake.
// Optional SNAP_TIMESTAMP_EN adds a tick-count timestamp to each snapshot. Rev 1.0
// ============================================================================
module board_io_sampler
   import types_pkg::*;
#(
   parameter int NUM_BTNS    = DEF_NUM_BTNS,
   parameter int SW_BITS     = DEF_SW_BITS,
   parameter int LED_BITS    = DEF_LED_BITS,
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int DEB_SAMPLES = DEF_DEB_SAMPLES
) (
   input  logic                CLOCK,
   input  logic                CPU_RESETN,
   input  logic [NUM_BTNS-1:0] BTN_RAW,
   input  logic [SW_BITS-1:0]  SW_RAW,
   input  logic [LED_BITS-1:0] LED_IN,
   output logic [SW_BITS-1:0]  SW_OUT,
   output logic [NUM_BTNS-1:0] BTN_LEVEL,
   output logic [NUM_BTNS-1:0] BTN_PRESS,
   input  logic                SNAP_CLR,
   output logic                SNAP_OVERRUN,
   board_io_sampler_if.master  snap
);
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0]    tick_cnt;
   logic                tick;
   logic [NUM_BTNS-1:0] btn_s1, btn_s2;
   logic [SW_BITS-1:0]  sw_s1, sw_s2;
   snap_state_t         state;
   logic                load;
   logic [SW_BITS-1:0]  snap_sw;
   logic [LED_BITS-1:0] snap_led;

   assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));
   // A tick captures from IDLE, or from HOLD when the consumer accepts in the same cycle.
   assign load = tick & ((state == IDLE) | snap.SNAP_READY);

   always_ff @(posedge CLOCK) begin
      if (!CPU_RESETN) begin
         tick_cnt <= '0;
         btn_s1   <= '0;
         btn_s2   <= '0;
         sw_s1    <= '0;
         sw_s2    <= '0;
         SW_OUT   <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
         btn_s1   <= BTN_RAW;
         btn_s2   <= btn_s1;
         sw_s1    <= SW_RAW;
         sw_s2    <= sw_s1;
         if (tick)
            SW_OUT <= sw_s2;
      end
   end

   generate
      for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
         btn_debounce #(
            .DEB_SAMPLES (DEB_SAMPLES)
         ) u_deb (
            .clk    (CLOCK),
            .rst_n  (CPU_RESETN),
            .tick   (tick),
            .sample (btn_s2[i]),
            .level  (BTN_LEVEL[i]),
            .press  (BTN_PRESS[i])
         );
      end
   endgenerate

`ifdef SNAP_TIMESTAMP_EN
   logic [31:0] tick_total;
   logic [31:0] snap_time;
`endif

   always_ff @(posedge CLOCK) begin
      if (!CPU_RESETN) begin
         state        <= IDLE;
         snap_sw      <= '0;
         snap_led     <= '0;
         SNAP_OVERRUN <= 1'b0;
`ifdef SNAP_TIMESTAMP_EN
         tick_total   <= '0;
         snap_time    <= '0;
`endif
      end else begin
         if (SNAP_CLR)
            SNAP_OVERRUN <= 1'b0;
         if (load) begin
            snap_sw   <= sw_s2;
            snap_led  <= LED_IN;
`ifdef SNAP_TIMESTAMP_EN
            snap_time <= tick_total;
`endif
         end
`ifdef SNAP_TIMESTAMP_EN
         if (tick)
            tick_total <= tick_total + 32'd1;
`endif
         case (state)
            IDLE: begin
               if (tick)
                  state <= HOLD;
            end
            HOLD: begin
               // Later assignment overrides SNAP_CLR so a coincident overrun wins.
               if (tick && !snap.SNAP_READY)
                  SNAP_OVERRUN <= 1'b1;
               else if (!tick && snap.SNAP_READY)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign snap.SNAP_VALID = (state == HOLD);
   assign snap.SNAP_SW    = snap_sw;
   assign snap.SNAP_LED   = snap_led;
`ifdef SNAP_TIMESTAMP_EN
   assign snap.SNAP_TIME  = snap_time;
`endif
endmodule
`default_nettype wire
